li_expander: RTL and testbench
==============================

# li_expander

Load-immediate expander for the single-cycle RISC-V core: it takes a 32-bit constant and a destination register and emits the minimal RV32I instruction sequence that materialises that constant. The sequence is ADDI alone, LUI alone, or LUI followed by ADDI. It performs the inverse of the core's immediate unit: it packs I-format and U-format immediate fields, where the core unpacks and sign-extends them. It sits between a program loader or test generator and instruction memory, and uses valid/ready handshakes on both sides.

## Interface
Parameters:
- COUNT_WIDTH, 16, width of the emitted-instruction counter.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset.
- req_valid_i  input  1  request present.
- req_ready_o  output  1  expander can accept a request.
- constant_i  input  32  value to load.
- rd_i  input  5  destination register.
- instr_valid_o  output  1  instr_o holds a valid instruction.
- instr_ready_i  input  1  consumer accepts instr_o.
- instr_o  output  32  encoded instruction.
- last_o  output  1  instr_o is the final instruction of the current sequence.
- count_o  output  COUNT_WIDTH  running count of instructions handed off.

## Operation
- Request capture: a request is accepted when req_valid_i and req_ready_o are both high. constant_i and rd_i are registered; the inputs are don't-care afterwards.
- Field split:
  - lo = C[11:0].
  - hi = (C + 32'h800)[31:12]; the sum wraps modulo 2^32.
- Case selection, evaluated in this priority order:
  - rd == 0: emit one canonical NOP, 32'h00000013.
  - C[31:11] all equal: emit ADDI rd, x0, lo.
  - lo == 0: emit LUI rd, C[31:12].
  - Otherwise: emit LUI rd, hi, then ADDI rd, rd, lo.
- Encodings:
  - LUI = {hi20, rd, 7'h37}.
  - ADDI = {imm12, rs1, 3'b000, rd, 7'h13}.
- FSM states:
  - IDLE: req_ready_o=1. On acceptance, go to FIRST.
  - FIRST: drive the first instruction. On handshake, go to SECOND for the two-instruction case; otherwise go to IDLE.
  - SECOND: drive the ADDI. On handshake, go to IDLE.
- last_o = 1 in SECOND and in FIRST for single-instruction sequences.
- count_o increments by 1 on every instr handshake and wraps from all-ones to 0.

## Timing
- Reset values: state=IDLE, req_ready_o=1, instr_valid_o=0, instr_o=0, last_o=0, count_o=0.
- Latency: instr_valid_o rises the cycle after request acceptance.
- Throughput:
  - req_ready_o is high only in IDLE, so no request is accepted in the cycle of a final handshake.
  - Minimum 2 cycles per single-instruction request, 3 per pair.
- Back-pressure: while instr_valid_o=1 and instr_ready_i=0, instr_o and last_o hold stable.
- Between the two instructions of a pair: instr_valid_o stays high (FIRST to SECOND) with no bubble.
- Reset mid-sequence: reset asserted in FIRST or SECOND immediately drops instr_valid_o. The partial sequence is abandoned and count_o clears.
- req_valid_i outside IDLE is ignored; no request is accepted or lost while busy.

## Structure
- A shared package holds:
  - OPC_LUI=7'h37 and OPC_ADDI=7'h13.
  - NOP=32'h00000013.
  - The state enum {IDLE, FIRST, SECOND}.
- Single sub-module li_split: combinational field split and case select, producing hi, lo and the case code. The top level holds the FSM, registers and counter.

## Test plan
- C=32'h12345678, rd=5 → two instructions, 32'h123452B7 then 32'h67828293; last_o asserted only on the second; count_o=2.
- C=32'hDEADBEEF, rd=10, instr_ready_i low for 3 cycles on each instruction → instr_o held stable; emits 32'hDEADC537 then 32'hEEF50513.
- C=32'hFFFFF800, rd=1 → single 32'h80000093 with last_o=1. C=32'h00001000, rd=2 → single 32'h00001137.
- C=32'h7FFFFFFF, rd=3 (hi wraps) → 32'h800001B7 then 32'hFFF18193. Same C with rd=0 → single 32'h00000013.
- Reset pulsed while in SECOND with instr_ready_i=0 → next cycle instr_valid_o=0, req_ready_o=1, count_o=0. A new request then completes normally.
- 65536 single-instruction requests → count_o wraps to 0; req_valid_i held high while busy never causes a duplicate accept.

Source files
------------

// File: rtl/li_expander_pkg.sv
// Shared constants, state and case types for the load-immediate expander.
package li_expander_pkg;

  localparam logic [6:0]  OPC_LUI  = 7'h37;
  localparam logic [6:0]  OPC_ADDI = 7'h13;
  localparam logic [31:0] NOP      = 32'h00000013;

  typedef enum logic [1:0] {
    IDLE,
    FIRST,
    SECOND
  } state_t;

  typedef enum logic [1:0] {
    K_NOP,
    K_ADDI,
    K_LUI,
    K_PAIR
  } kind_t;

  function automatic logic [31:0] enc_lui(
    input logic [19:0] imm,
    input logic [4:0]  rd
  );
    return {imm, rd, OPC_LUI};
  endfunction

  function automatic logic [31:0] enc_addi(
    input logic [11:0] imm,
    input logic [4:0]  rs1,
    input logic [4:0]  rd
  );
    return {imm, rs1, 3'b000, rd, OPC_ADDI};
  endfunction

endpackage

// File: rtl/li_split.sv
// Splits a constant into LUI/ADDI fields and picks the shortest sequence.
module li_split
  import li_expander_pkg::*;
(
  input  logic [31:0] value,
  input  logic [4:0]  rd,
  output logic [19:0] hi,
  output logic [11:0] lo,
  output kind_t       kind
);

  logic sign_run;

  // (C + 0x800) >> 12 without carrying the unused low bits
  assign hi = value[31:12] + {19'd0, value[11]};
  assign lo = value[11:0];

  assign sign_run = (value[31:11] == '0) || (value[31:11] == '1);

  always_comb begin
    kind = K_PAIR;
    if (rd == 5'd0)
      kind = K_NOP;
    else if (sign_run)
      kind = K_ADDI;
    else if (lo == 12'd0)
      kind = K_LUI;
  end

endmodule

// File: rtl/li_expander.sv
// Emits the minimal LUI/ADDI sequence that loads a 32-bit constant into rd.
module li_expander
  import li_expander_pkg::*;
#(
  parameter int COUNT_WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   req_valid_i,
  output logic                   req_ready_o,
  input  logic [31:0]            constant_i,
  input  logic [4:0]             rd_i,
  output logic                   instr_valid_o,
  input  logic                   instr_ready_i,
  output logic [31:0]            instr_o,
  output logic                   last_o,
  output logic [COUNT_WIDTH-1:0] count_o
);

  state_t state, next;

  logic [31:0] c_q;
  logic [4:0]  rd_q;
  logic [19:0] hi;
  logic [11:0] lo;
  kind_t       kind;
  logic        fire;

  li_split u_split (
    .value (c_q),
    .rd    (rd_q),
    .hi    (hi),
    .lo    (lo),
    .kind  (kind)
  );

  assign fire = instr_valid_o & instr_ready_i;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      c_q     <= '0;
      rd_q    <= '0;
      count_o <= '0;
    end else begin
      state <= next;
      if (state == IDLE && req_valid_i) begin
        c_q  <= constant_i;
        rd_q <= rd_i;
      end
      if (fire)
        count_o <= count_o + 1'b1;
    end
  end

  always_comb begin
    next          = state;
    req_ready_o   = 1'b0;
    instr_valid_o = 1'b0;
    instr_o       = '0;
    last_o        = 1'b0;
    unique case (state)
      IDLE: begin
        req_ready_o = 1'b1;
        if (req_valid_i)
          next = FIRST;
      end
      FIRST: begin
        instr_valid_o = 1'b1;
        last_o        = (kind != K_PAIR);
        unique case (kind)
          K_NOP:   instr_o = NOP;
          K_ADDI:  instr_o = enc_addi(lo, 5'd0, rd_q);
          K_LUI:   instr_o = enc_lui(c_q[31:12], rd_q);
          default: instr_o = enc_lui(hi, rd_q);
        endcase
        if (instr_ready_i)
          next = (kind == K_PAIR) ? SECOND : IDLE;
      end
      SECOND: begin
        instr_valid_o = 1'b1;
        last_o        = 1'b1;
        instr_o       = enc_addi(lo, rd_q, rd_q);
        if (instr_ready_i)
          next = IDLE;
      end
      default: next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_li_expander.sv
// Directed self-checking bench for li_expander.
module tb_li_expander;

  localparam int CW = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic          req_valid_i;
  logic          req_ready_o;
  logic [31:0]   constant_i;
  logic [4:0]    rd_i;
  logic          instr_valid_o;
  logic          instr_ready_i;
  logic [31:0]   instr_o;
  logic          last_o;
  logic [CW-1:0] count_o;

  int tests = 0;
  int fails = 0;

  li_expander #(.COUNT_WIDTH(CW)) dut (
    .clk           (clk),
    .reset         (reset),
    .req_valid_i   (req_valid_i),
    .req_ready_o   (req_ready_o),
    .constant_i    (constant_i),
    .rd_i          (rd_i),
    .instr_valid_o (instr_valid_o),
    .instr_ready_i (instr_ready_i),
    .instr_o       (instr_o),
    .last_o        (last_o),
    .count_o       (count_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [31:0] c, input logic [4:0] r);
    chk("idle_ready", {31'd0, req_ready_o}, 32'd1);
    req_valid_i = 1'b1;
    constant_i  = c;
    rd_i        = r;
    @(negedge clk);
    req_valid_i = 1'b0;
    constant_i  = 32'hA5A5A5A5;
    rd_i        = 5'd31;
  endtask

  task automatic take(input string tag, input logic [31:0] ins,
                      input logic lst, input int stall);
    instr_ready_i = 1'b0;
    repeat (stall) begin
      chk({tag, "_hold_v"}, {31'd0, instr_valid_o}, 32'd1);
      chk({tag, "_hold_i"}, instr_o, ins);
      chk({tag, "_hold_l"}, {31'd0, last_o}, {31'd0, lst});
      @(negedge clk);
    end
    instr_ready_i = 1'b1;
    chk({tag, "_v"}, {31'd0, instr_valid_o}, 32'd1);
    chk({tag, "_i"}, instr_o, ins);
    chk({tag, "_l"}, {31'd0, last_o}, {31'd0, lst});
    chk({tag, "_busy"}, {31'd0, req_ready_o}, 32'd0);
    @(negedge clk);
    instr_ready_i = 1'b0;
  endtask

  initial begin
    reset         = 1'b0;
    req_valid_i   = 1'b0;
    constant_i    = '0;
    rd_i          = '0;
    instr_ready_i = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_ready", {31'd0, req_ready_o}, 32'd1);
    chk("rst_valid", {31'd0, instr_valid_o}, 32'd0);
    chk("rst_instr", instr_o, 32'd0);
    chk("rst_last", {31'd0, last_o}, 32'd0);
    chk("rst_count", {24'd0, count_o}, 32'd0);
    reset = 1'b1;
    @(negedge clk);

    send(32'h12345678, 5'd5);
    take("p1a", 32'h123452B7, 1'b0, 0);
    take("p1b", 32'h67828293, 1'b1, 0);
    chk("p1_count", {24'd0, count_o}, 32'd2);
    chk("p1_idle", {31'd0, instr_valid_o}, 32'd0);

    send(32'hDEADBEEF, 5'd10);
    take("p2a", 32'hDEADC537, 1'b0, 3);
    take("p2b", 32'hEEF50513, 1'b1, 3);
    chk("p2_count", {24'd0, count_o}, 32'd4);

    send(32'hFFFFF800, 5'd1);
    take("s_addi", 32'h80000093, 1'b1, 0);
    send(32'h00001000, 5'd2);
    take("s_lui", 32'h00001137, 1'b1, 0);

    send(32'h7FFFFFFF, 5'd3);
    take("wrap_a", 32'h800001B7, 1'b0, 0);
    take("wrap_b", 32'hFFF18193, 1'b1, 0);
    send(32'h7FFFFFFF, 5'd0);
    take("nop", 32'h00000013, 1'b1, 1);
    chk("s_count", {24'd0, count_o}, 32'd9);

    send(32'h12345678, 5'd5);
    take("mr_a", 32'h123452B7, 1'b0, 0);
    chk("mr_second", {31'd0, instr_valid_o}, 32'd1);
    reset = 1'b0;
    #1;
    chk("mr_valid", {31'd0, instr_valid_o}, 32'd0);
    chk("mr_ready", {31'd0, req_ready_o}, 32'd1);
    chk("mr_count", {24'd0, count_o}, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    send(32'h00001000, 5'd2);
    take("mr_new", 32'h00001137, 1'b1, 0);
    chk("mr_new_cnt", {24'd0, count_o}, 32'd1);

    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    req_valid_i   = 1'b1;
    constant_i    = 32'h00000005;
    rd_i          = 5'd1;
    instr_ready_i = 1'b1;
    repeat (2 * 255) @(negedge clk);
    chk("cnt_255", {24'd0, count_o}, 32'd255);
    chk("cnt_idle", {31'd0, req_ready_o}, 32'd1);
    repeat (2) @(negedge clk);
    chk("cnt_wrap", {24'd0, count_o}, 32'd0);
    req_valid_i = 1'b0;
    @(negedge clk);
    chk("cnt_instr", instr_o, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
